// File: rtl/dcache_line_fill_if.sv
// Memory read port between the line-fill engine and the external memory.
// The fill engine is the master: it holds a request and address until a valid data beat arrives.
interface dcache_line_fill_if #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32
);
  logic                mem_rd_req;
  logic [ADDRBITS-1:0] mem_addr;
  logic                mem_rd_valid;
  logic [DATABITS-1:0] mem_rdata;

  modport master (output mem_rd_req, mem_addr, input  mem_rd_valid, mem_rdata);
  modport slave  (input  mem_rd_req, mem_addr, output mem_rd_valid, mem_rdata);
endinterface

// File: rtl/dcache_line_fill.sv
// Dcache line-fill responder: reads one aligned line from memory into the victim's data RAM,
// then commits its tag/valid bit. All outputs are registered.
module dcache_line_fill #(
  parameter int ADDRBITS      = 32,
  parameter int DATABITS      = 32,
  parameter int LINES         = 4,
  parameter int CACHEADDRBITS = 5,
  parameter int TAGBITS       = ADDRBITS - CACHEADDRBITS - 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [LINES-1:0]         fill_req,
  input  logic [ADDRBITS-1:0]      miss_addr,
  output logic                     fill_busy,
  output logic [LINES-1:0]         fill_done,
  dcache_line_fill_if.master       mem,
  output logic [LINES-1:0]         line_we,
  output logic [CACHEADDRBITS-1:0] line_waddr,
  output logic [DATABITS-1:0]      line_wdata,
  output logic [LINES-1:0]         tag_we,
  output logic [TAGBITS-1:0]       tag_wdata
);

  localparam int                       OFFBITS  = CACHEADDRBITS + 2;
  localparam logic [ADDRBITS-1:0]      OFF_MASK = ADDRBITS'((1 << OFFBITS) - 1);
  localparam logic [CACHEADDRBITS-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {IDLE, READ, LAST, DONE, COOL} state_t;

  state_t                   state, state_d;
  logic [LINES-1:0]         victim, victim_d;
  logic [ADDRBITS-1:0]      base, base_d;
  logic [TAGBITS-1:0]       tag, tag_d;
  logic [CACHEADDRBITS-1:0] idx, idx_d;

  logic                     fill_busy_d, mem_rd_req_d;
  logic [ADDRBITS-1:0]      mem_addr_d;
  logic [LINES-1:0]         fill_done_d, line_we_d, tag_we_d;
  logic [CACHEADDRBITS-1:0] line_waddr_d;
  logic [DATABITS-1:0]      line_wdata_d;
  logic [TAGBITS-1:0]       tag_wdata_d;
  logic                     beat;

  // Isolates the lowest set bit so a multi-hot request still picks exactly one victim.
  function automatic logic [LINES-1:0] lowest_one(input logic [LINES-1:0] v);
    return v & (~v + LINES'(1));
  endfunction

  assign beat = mem.mem_rd_req && mem.mem_rd_valid;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state;
    victim_d     = victim;
    base_d       = base;
    tag_d        = tag;
    idx_d        = idx;
    mem_rd_req_d = mem.mem_rd_req;
    mem_addr_d   = mem.mem_addr;
    line_waddr_d = line_waddr;
    line_wdata_d = line_wdata;
    line_we_d    = '0;
    fill_done_d  = '0;
    tag_we_d     = '0;
    tag_wdata_d  = '0;

    unique case (state)
      IDLE: begin
        if (|fill_req) begin
          victim_d     = lowest_one(fill_req);
          base_d       = miss_addr & ~OFF_MASK;
          tag_d        = miss_addr[ADDRBITS-1 -: TAGBITS];
          idx_d        = '0;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = miss_addr & ~OFF_MASK;
          state_d      = READ;
        end
      end
      READ: begin
        if (beat) begin
          line_we_d    = victim;
          line_waddr_d = idx;
          line_wdata_d = mem.mem_rdata;
          idx_d        = idx + CACHEADDRBITS'(1);
          mem_addr_d   = base + ADDRBITS'({idx_d, 2'b00});
          if (idx == LAST_IDX) begin
            mem_rd_req_d = 1'b0;
            state_d      = LAST;
          end
        end
      end
      LAST: begin
        fill_done_d = victim;
        tag_we_d    = victim;
        tag_wdata_d = tag;
        state_d     = DONE;
      end
      DONE:    state_d = COOL;
      // Gives the controller's registered fill_req a cycle to observe the now-valid line.
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    fill_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      victim         <= '0;
      base           <= '0;
      tag            <= '0;
      idx            <= '0;
      fill_busy      <= 1'b0;
      fill_done      <= '0;
      mem.mem_rd_req <= 1'b0;
      mem.mem_addr   <= '0;
      line_we        <= '0;
      line_waddr     <= '0;
      line_wdata     <= '0;
      tag_we         <= '0;
      tag_wdata      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state          <= state_d;
      victim         <= victim_d;
      base           <= base_d;
      tag            <= tag_d;
      idx            <= idx_d;
      fill_busy      <= fill_busy_d;
      fill_done      <= fill_done_d;
      mem.mem_rd_req <= mem_rd_req_d;
      mem.mem_addr   <= mem_addr_d;
      line_we        <= line_we_d;
      line_waddr     <= line_waddr_d;
      line_wdata     <= line_wdata_d;
      tag_we         <= tag_we_d;
      tag_wdata      <= tag_wdata_d;
    end
  end

endmodule
